sel_sequencer: RTL and testbench

Generates the 2-bit channel-select word that drives the downstream 4:1 data multiplexer's sel input, from board push-buttons and a mode switch. Two modes are supported. In manual mode, debounced next/prev buttons step sel up or down. In auto mode, sel advances every SCAN_CYCLES clocks. A one-cycle strobe marks every change of sel.

---
 rtl/sel_sequencer_pkg.sv | 11 +
 rtl/sel_sequencer_debounce.sv | 42 ++++
 rtl/sel_sequencer.sv | 83 ++++++++
 tb/tb_sel_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/sel_sequencer_pkg.sv
// rtl/sel_sequencer_pkg.sv - state encoding and select width shared with the mux stage
package sel_sequencer_pkg;

  localparam int SEL_W = 2;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_t;

endpackage

// File: rtl/sel_sequencer_debounce.sv
// rtl/sel_sequencer_debounce.sv - button synchronizer, debouncer and press detector
module debounce_pulse #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync    <= {sync[0], raw_in};
      level_q <= level;
      // Any cycle of agreement restarts the stability window
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/sel_sequencer.sv
// rtl/sel_sequencer.sv - channel-select sequencer with manual step and auto-scan modes
module sel_sequencer
  import sel_sequencer_pkg::*;
#(
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int SCAN_CYCLES = 100_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             auto_en,
  output logic [SEL_W-1:0] sel,
  output logic             sel_chg,
  output logic             auto_mode
);

  localparam int SCAN_W = $clog2(SCAN_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

  logic              next_press, prev_press;
  logic              unused_next_level, unused_prev_level;
  logic [1:0]        auto_sync;
  logic [SCAN_W-1:0] scan_cnt;
  state_t            state;

  debounce_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_next (
    .clk    (clk),
    .reset  (reset),
    .raw_in (btn_next),
    .level  (unused_next_level),
    .press  (next_press)
  );

  debounce_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_prev (
    .clk    (clk),
    .reset  (reset),
    .raw_in (btn_prev),
    .level  (unused_prev_level),
    .press  (prev_press)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_sync <= '0;
      state     <= MANUAL;
      sel       <= '0;
      sel_chg   <= 1'b0;
      auto_mode <= 1'b0;
      scan_cnt  <= '0;
    end else begin
      auto_sync <= {auto_sync[0], auto_en};
      sel_chg   <= 1'b0;
      case (state)
        MANUAL: begin
          // Mode change takes the whole cycle; a coincident press is dropped
          if (auto_sync[1]) begin
            state     <= AUTO;
            auto_mode <= 1'b1;
            scan_cnt  <= '0;
          end else if (next_press ^ prev_press) begin
            sel     <= next_press ? sel + SEL_W'(1) : sel - SEL_W'(1);
            sel_chg <= 1'b1;
          end
        end
        AUTO: begin
          if (!auto_sync[1]) begin
            state     <= MANUAL;
            auto_mode <= 1'b0;
            scan_cnt  <= '0;
          end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            sel      <= sel + SEL_W'(1);
            sel_chg  <= 1'b1;
          end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sel_sequencer.sv
// tb/tb_sel_sequencer.sv - directed self-checking bench for sel_sequencer
module tb_sel_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_next, btn_prev, auto_en;
  logic [1:0] sel;
  logic       sel_chg, auto_mode;
  int         checks = 0;
  int         errors = 0;

  sel_sequencer #(.DEB_CYCLES(4), .SCAN_CYCLES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_next  (btn_next),
    .btn_prev  (btn_prev),
    .auto_en   (auto_en),
    .sel       (sel),
    .sel_chg   (sel_chg),
    .auto_mode (auto_mode)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Holds the buttons for 'hold' edges, then watches 16 edges in total
  task automatic press(input logic nx, input logic pv, input int hold,
                       input logic [1:0] old_sel, input logic [1:0] exp_sel,
                       input int exp_pulses, input int exp_at, input string tag);
    int pulses;
    int at;
    pulses   = 0;
    at       = -1;
    btn_next = nx;
    btn_prev = pv;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      if (i == hold) begin
        btn_next = 1'b0;
        btn_prev = 1'b0;
      end
      if (sel_chg === 1'b1) begin
        pulses++;
        if (at < 0) at = i;
      end
      if (i == 6) chk({tag, " sel_before"}, sel, old_sel);
    end
    chk({tag, " sel_after"}, sel, exp_sel);
    chk({tag, " chg_pulses"}, pulses, exp_pulses);
    chk({tag, " chg_edge"}, at, exp_at);
  endtask

  initial begin
    int pulses;
    reset    = 1'b1;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    auto_en  = 1'b0;
    tick(3);
    reset = 1'b0;
    chk("reset sel", sel, 0);
    chk("reset sel_chg", sel_chg, 0);
    chk("reset auto_mode", auto_mode, 0);

    press(1, 0, 10, 0, 1, 1, 7, "next1");
    press(1, 0, 10, 1, 2, 1, 7, "next2");
    press(1, 0, 10, 2, 3, 1, 7, "next3");
    press(1, 0, 10, 3, 0, 1, 7, "next_wrap");
    press(0, 1, 10, 0, 3, 1, 7, "prev_wrap");
    press(1, 0, 3, 3, 3, 0, -1, "glitch");
    press(1, 1, 10, 3, 3, 0, -1, "both");
    press(0, 1, 10, 3, 2, 1, 7, "prev");

    auto_en = 1'b1;
    tick(2);
    chk("auto_mode pre", auto_mode, 0);
    tick(1);
    chk("auto_mode on", auto_mode, 1);
    chk("auto entry sel", sel, 2);
    pulses = 0;
    for (int j = 1; j <= 24; j++) begin
      @(posedge clk);
      #1;
      if (j == 1) btn_next = 1'b1;
      if (j == 11) btn_next = 1'b0;
      if (sel_chg === 1'b1) pulses++;
      if (j == 7) chk("auto hold", sel, 2);
      if (j == 8) chk("auto step1", {sel_chg, sel}, {1'b1, 2'd3});
      if (j == 16) chk("auto step2", {sel_chg, sel}, {1'b1, 2'd0});
      if (j == 24) chk("auto step3", {sel_chg, sel}, {1'b1, 2'd1});
    end
    chk("auto pulses", pulses, 3);

    auto_en = 1'b0;
    tick(2);
    chk("auto_mode hold", auto_mode, 1);
    tick(1);
    chk("auto_mode off", auto_mode, 0);
    tick(4);
    chk("manual hold sel", sel, 1);
    chk("manual hold chg", sel_chg, 0);
    press(1, 0, 10, 1, 2, 1, 7, "after_auto");

    btn_next = 1'b1;
    tick(3);
    #3 reset = 1'b1;
    #1;
    chk("async rst sel", sel, 0);
    chk("async rst chg", sel_chg, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    press(1, 0, 10, 0, 1, 1, 7, "rst_held");

    auto_en = 1'b1;
    tick(4);
    chk("auto re-entry", auto_mode, 1);
    #3 reset = 1'b1;
    #1;
    chk("async rst auto_mode", auto_mode, 0);
    chk("async rst sel2", sel, 0);
    auto_en = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
